// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL dynamic-phase controller.
// PRST exists only when PLL_LOCK_WATCHDOG_EN is defined.
package pll_ctrl_pkg;

  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] PHASE_SEL_MAX = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    STEP      = 3'd2,
    GAP       = 3'd3,
    LOAD      = 3'd4,
    WAIT_LOCK = 3'd5
`ifdef PLL_LOCK_WATCHDOG_EN
    ,
    PRST      = 3'd6
`endif
  } state_t;

  // Selects 0-4 address CLKOUT0-4, 5 addresses feedback; 6-7 are unused codes.
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return (sel <= PHASE_SEL_MAX);
  endfunction

endpackage

// File: rtl/pll_lock_mon.sv
// Counts consecutive synchronised lock-low cycles while enabled; flags
// expiry on the LOCK_TIMEOUT-th consecutive low cycle.
module pll_lock_mon #(
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic lock,
  output logic expired
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || lock) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(LOCK_TIMEOUT - 1)) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = enable && !lock && (cnt == CNT_W'(LOCK_TIMEOUT - 1));

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PLL dynamic phase-shift requests (step pulses, load, relock wait).
// Optional PLL_LOCK_WATCHDOG_EN adds lock-loss recovery through a PLL reset pulse.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int STEP_GAP     = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int RST_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_dir,
  input  logic [7:0]       req_steps,
  output logic             done,
  output logic             err,
  output logic             busy,
  input  logic             pll_lock,
  output logic [SEL_W-1:0] phase_sel,
  output logic             phase_dir,
  output logic             phase_step_n,
  output logic             load_phase,
  output logic             pll_rst
);

  localparam int MAX_A   = (STEP_GAP > LOCK_TIMEOUT) ? STEP_GAP : LOCK_TIMEOUT;
  localparam int TMR_MAX = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t           state, next_state;
  logic [7:0]       steps_left, steps_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             lock_meta, lock_sync;
  logic             accept, done_s, err_s, capture_s;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state == IDLE) && lock_sync && !rst;
  assign busy      = (state != IDLE);

`ifdef PLL_LOCK_WATCHDOG_EN
  logic active, active_nxt;
  logic retried, retried_nxt;
  logic wd_expired;

  pll_lock_mon #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_mon (
    .clk     (clk),
    .rst     (rst),
    .enable  (state == IDLE),
    .lock    (lock_sync),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  always_comb begin
    next_state = state;
    steps_nxt  = steps_left;
    tmr_nxt    = tmr;
    done_s     = 1'b0;
    err_s      = 1'b0;
    capture_s  = 1'b0;
`ifdef PLL_LOCK_WATCHDOG_EN
    active_nxt  = active;
    retried_nxt = retried;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (!sel_valid(req_sel)) begin
            done_s = 1'b1;
            err_s  = 1'b1;
          end else begin
            capture_s = 1'b1;
            if (req_steps == 8'd0) begin
              done_s = 1'b1;
            end else begin
              next_state = SETUP;
              steps_nxt  = req_steps;
`ifdef PLL_LOCK_WATCHDOG_EN
              active_nxt  = 1'b1;
              retried_nxt = 1'b0;
`endif
            end
          end
`ifdef PLL_LOCK_WATCHDOG_EN
        end else if (wd_expired) begin
          // Lock lost with no request pending: recover silently.
          next_state  = PRST;
          tmr_nxt     = '0;
          active_nxt  = 1'b0;
          retried_nxt = 1'b0;
`endif
        end else begin
          next_state = IDLE;
        end
      end
      SETUP: next_state = STEP;
      STEP: begin
        steps_nxt  = steps_left - 8'd1;
        tmr_nxt    = '0;
        next_state = GAP;
      end
      GAP: begin
        if (tmr == TMR_W'(STEP_GAP - 1)) begin
          next_state = (steps_left == 8'd0) ? LOAD : STEP;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      LOAD: begin
        tmr_nxt    = '0;
        next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_sync) begin
          next_state = IDLE;
`ifdef PLL_LOCK_WATCHDOG_EN
          done_s = active;
`else
          done_s = 1'b1;
`endif
        end else if (tmr == TMR_W'(LOCK_TIMEOUT - 1)) begin
`ifdef PLL_LOCK_WATCHDOG_EN
          if (retried) begin
            next_state = IDLE;
            done_s     = active;
            err_s      = active;
          end else begin
            next_state  = PRST;
            tmr_nxt     = '0;
            retried_nxt = 1'b1;
          end
`else
          next_state = IDLE;
          done_s     = 1'b1;
          err_s      = 1'b1;
`endif
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
`ifdef PLL_LOCK_WATCHDOG_EN
      PRST: begin
        if (tmr == TMR_W'(RST_CYCLES - 1)) begin
          tmr_nxt    = '0;
          next_state = WAIT_LOCK;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Pin registers are loaded from next_state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      steps_left   <= 8'd0;
      tmr          <= '0;
      phase_sel    <= '0;
      phase_dir    <= 1'b0;
      phase_step_n <= 1'b1;
      load_phase   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= next_state;
      steps_left   <= steps_nxt;
      tmr          <= tmr_nxt;
      phase_step_n <= (next_state != STEP);
      load_phase   <= (next_state == LOAD);
      done         <= done_s;
      err          <= err_s;
      if (capture_s) begin
        phase_sel <= req_sel;
        phase_dir <= req_dir;
      end else begin
        phase_sel <= phase_sel;
        phase_dir <= phase_dir;
      end
    end
  end

`ifdef PLL_LOCK_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      retried <= 1'b0;
      pll_rst <= 1'b0;
    end else begin
      active  <= active_nxt;
      retried <= retried_nxt;
      pll_rst <= (next_state == PRST);
    end
  end
`else
  assign pll_rst = 1'b0;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: table vectors, random requests
// against an arithmetic timing model, and hand-written reset/lock sequences.
module tb_pll_phase_ctrl;

  localparam int G  = 2;
  localparam int TO = 8;
  localparam int RC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_sel = 3'd0;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic       done, err, busy;
  logic       pll_lock = 1'b1;
  logic [2:0] phase_sel;
  logic       phase_dir, phase_step_n, load_phase, pll_rst;

  int vecs = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [2:0] exp_sel = 3'd0;
  logic       exp_dir = 1'b0;

  typedef struct {
    logic [2:0] sel;
    logic       dir;
    logic [7:0] steps;
    int         exp_done;
    logic       exp_err;
  } vec_t;

  vec_t tbl[7];

  pll_phase_ctrl #(.STEP_GAP(G), .LOCK_TIMEOUT(TO), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .done(done), .err(err), .busy(busy), .pll_lock(pll_lock),
    .phase_sel(phase_sel), .phase_dir(phase_dir), .phase_step_n(phase_step_n),
    .load_phase(load_phase), .pll_rst(pll_rst)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Completion cycle relative to the accept cycle (cycle 0).
  function automatic void calc(input logic [2:0] sel, input logic [7:0] steps,
                               input int drop_c, output int done_c, output bit err_e);
    int load_c;
    load_c = 2 + int'(steps) * (G + 1);
    if (sel > 3'd5) begin
      done_c = 1; err_e = 1'b1;
    end else if (steps == 8'd0) begin
      done_c = 1; err_e = 1'b0;
    end else if (drop_c == 0) begin
      done_c = load_c + 2; err_e = 1'b0;
    end else begin
`ifdef PLL_LOCK_WATCHDOG_EN
      done_c = load_c + 1 + TO + RC + 1; err_e = 1'b0;
`else
      done_c = load_c + 1 + TO; err_e = 1'b1;
`endif
    end
  endfunction

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) ok = 1'b1;
    end
    chk("ready_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_trace(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                             input int done_c, input bit err_e, input int drop_c, input bit hold);
    bit valid, has, step_e, load_e, busy_e, rst_e;
    int load_c, prst_s, prst_e;
    valid  = (sel <= 3'd5);
    has    = valid && (steps != 8'd0);
    load_c = 2 + int'(steps) * (G + 1);
    prst_s = load_c + 1 + TO;
    prst_e = prst_s + RC - 1;
    if (valid) begin
      exp_sel = sel;
      exp_dir = dir;
    end
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      cyc    = c;
      step_e = has && c >= 2 && ((c - 2) % (G + 1) == 0) && ((c - 2) / (G + 1) < int'(steps));
      load_e = has && (c == load_c);
      busy_e = has && (c < done_c);
`ifdef PLL_LOCK_WATCHDOG_EN
      rst_e  = has && (drop_c != 0) && (c >= prst_s) && (c <= prst_e);
`else
      rst_e  = 1'b0;
`endif
      chk("phase_step_n", {31'd0, phase_step_n}, {31'd0, !step_e});
      chk("load_phase", {31'd0, load_phase}, {31'd0, load_e});
      chk("done", {31'd0, done}, {31'd0, c == done_c});
      chk("err", {31'd0, err}, {31'd0, (c == done_c) && err_e});
      chk("busy", {31'd0, busy}, {31'd0, busy_e});
      chk("pll_rst", {31'd0, pll_rst}, {31'd0, rst_e});
      chk("phase_sel", {29'd0, phase_sel}, {29'd0, exp_sel});
      chk("phase_dir", {31'd0, phase_dir}, {31'd0, exp_dir});
      if (drop_c == 0) chk("req_ready", {31'd0, req_ready}, {31'd0, !busy_e});
      if (hold && c == 1) begin
        req_valid = 1'b1; req_sel = 3'd3; req_dir = ~dir; req_steps = 8'd1;
      end
      if (drop_c != 0 && c == drop_c) pll_lock = 1'b0;
`ifdef PLL_LOCK_WATCHDOG_EN
      if (drop_c != 0 && c == prst_s) pll_lock = 1'b1;
`endif
    end
  endtask

  task automatic run_req(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                         input int done_c, input bit err_e, input int drop_c, input bit hold);
    wait_ready();
    req_valid = 1'b1; req_sel = sel; req_dir = dir; req_steps = steps;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_trace(sel, dir, steps, done_c, err_e, drop_c, hold);
    if (hold) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_trace(3'd3, ~dir, 8'd1, 2 + (G + 1) + 2, 1'b0, 0, 1'b0);
    end
    @(negedge clk);
    cyc = cyc + 1;
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   dc;
    bit   de;
    int   n;
    logic [2:0] rs;
    logic [7:0] rn;

    tbl[0] = '{sel: 3'd2, dir: 1'b1, steps: 8'd3,   exp_done: 13,  exp_err: 1'b0};
    tbl[1] = '{sel: 3'd0, dir: 1'b0, steps: 8'd0,   exp_done: 1,   exp_err: 1'b0};
    tbl[2] = '{sel: 3'd7, dir: 1'b1, steps: 8'd5,   exp_done: 1,   exp_err: 1'b1};
    tbl[3] = '{sel: 3'd6, dir: 1'b0, steps: 8'd9,   exp_done: 1,   exp_err: 1'b1};
    tbl[4] = '{sel: 3'd5, dir: 1'b0, steps: 8'd1,   exp_done: 7,   exp_err: 1'b0};
    tbl[5] = '{sel: 3'd4, dir: 1'b1, steps: 8'd2,   exp_done: 10,  exp_err: 1'b0};
    tbl[6] = '{sel: 3'd3, dir: 1'b0, steps: 8'd255, exp_done: 769, exp_err: 1'b0};

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    chk("rst_step_n", {31'd0, phase_step_n}, 32'd1);
    chk("rst_phase_sel", {29'd0, phase_sel}, 32'd0);
    chk("rst_phase_dir", {31'd0, phase_dir}, 32'd0);
    chk("rst_load", {31'd0, load_phase}, 32'd0);
    chk("rst_pll_rst", {31'd0, pll_rst}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_req(tbl[i].sel, tbl[i].dir, tbl[i].steps, tbl[i].exp_done, tbl[i].exp_err, 0, 1'b0);

    // Request held during busy is ignored, then taken at completion.
    run_req(3'd1, 1'b1, 8'd2, 10, 1'b0, 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      rs = 3'($urandom_range(0, 7));
      rn = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      calc(rs, rn, 0, dc, de);
      run_req(rs, 1'($urandom_range(0, 1)), rn, dc, de, 0, 1'b0);
    end

    // Lock lost before LOAD.
    calc(3'd1, 8'd2, 3, dc, de);
    run_req(3'd1, 1'b0, 8'd2, dc, de, 3, 1'b0);
    pll_lock = 1'b1;

    // Reset in the middle of a step sequence.
    wait_ready();
    req_valid = 1'b1; req_sel = 3'd2; req_dir = 1'b1; req_steps = 8'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      cyc = c;
      chk("abort_step_n", {31'd0, phase_step_n}, {31'd0, c != 2});
      chk("abort_load", {31'd0, load_phase}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      if (c >= 5) begin
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_phase_sel", {29'd0, phase_sel}, 32'd0);
      end
      if (c == 4) rst = 1'b1;
      if (c == 6) rst = 1'b0;
    end
    exp_sel = 3'd0;
    exp_dir = 1'b0;
    wait_ready();

`ifdef PLL_LOCK_WATCHDOG_EN
    // Lock loss while idle triggers a PLL reset pulse and no done.
    pll_lock = 1'b0;
    n = 0;
    for (int i = 0; i < TO + 6 && pll_rst !== 1'b1; i++) begin
      @(negedge clk);
      chk("wd_no_done", {31'd0, done}, 32'd0);
    end
    chk("wd_rst_rise", {31'd0, pll_rst}, 32'd1);
    pll_lock = 1'b1;
    for (int i = 0; i < 40 && pll_rst === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
    chk("wd_rst_len", n, RC);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("wd_no_done", {31'd0, done}, 32'd0);
    end
    wait_ready();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
